// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types and constants for the countdown timer.
//   state_t          - controller state (IDLE, RUN, PAUSE, EXPIRED), 2-bit encoding
//   MAX_LOAD_DEFAULT - default saturation limit for loaded values (keeps BCD at two digits)
//   BCD_NINE         - ones-digit value after a borrow in the BCD decrement
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam int         MAX_LOAD_DEFAULT = 99;
    localparam logic [3:0] BCD_NINE         = 4'd9;

endpackage

// File: rtl/countdown_timer_bin2bcd_99.sv
// bin2bcd_99: combinational 7-bit binary to two-digit BCD for inputs 0..99.
//   bin  - binary value, expected in 0..99
//   tens - BCD tens digit
//   ones - BCD ones digit
// The tens digit is found by threshold compares rather than division; inputs
// above 99 are out of range and give no meaningful digits.
module bin2bcd_99 (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [3:0] t;

    always_comb begin
        t = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (bin >= 7'(10 * i))
                t = 4'(i);
        end
        tens = t;
        ones = 4'(bin - 7'(10 * t));
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable seconds down-counter on the 1 Hz domain.
//   clk_1Hz  - counting clock, all state on posedge
//   rst      - asynchronous active-high reset
//   load     - synchronous load strobe (highest priority)
//   load_val - value to load, saturated to MAX_LOAD
//   start    - begin / resume counting
//   pause    - freeze counting (wins over start)
//   count    - remaining seconds, binary
//   tens     - BCD tens digit of count
//   ones     - BCD ones digit of count
//   running  - high while counting
//   done     - one-cycle pulse after the edge where count goes 1 -> 0
//   expired  - high while halted at zero
// Binary and BCD views are updated together; the BCD view is converted only
// on load and otherwise decremented digit-wise, so count == 10*tens + ones
// holds after every edge.
import countdown_pkg::*;

module countdown_timer #(
    parameter int WIDTH    = 7,
    parameter int MAX_LOAD = MAX_LOAD_DEFAULT
) (
    input  logic             clk_1Hz,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic             running,
    output logic             done,
    output logic             expired
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [3:0]       tens_nxt, ones_nxt;
    logic             done_nxt;

    logic [WIDTH-1:0] load_sat;
    logic [6:0]       load_bin;
    logic [3:0]       ld_tens, ld_ones;

    // Saturate first so the converter only ever sees 0..MAX_LOAD.
    assign load_sat = (load_val > WIDTH'(MAX_LOAD)) ? WIDTH'(MAX_LOAD) : load_val;
    assign load_bin = 7'(load_sat);

    bin2bcd_99 u_bin2bcd (
        .bin  (load_bin),
        .tens (ld_tens),
        .ones (ld_ones)
    );

    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            tens  <= 4'd0;
            ones  <= 4'd0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            tens  <= tens_nxt;
            ones  <= ones_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        tens_nxt  = tens;
        ones_nxt  = ones;
        done_nxt  = 1'b0;

        if (load) begin
            state_nxt = IDLE;
            count_nxt = load_sat;
            tens_nxt  = ld_tens;
            ones_nxt  = ld_ones;
        end else begin
            case (state)
                IDLE: begin
                    // Starting from zero would expire instantly; stay put instead.
                    if (start && !pause && count != '0)
                        state_nxt = RUN;
                end
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSE;
                    end else if (count == '0) begin
                        // Unreachable in normal operation; never decrement through zero.
                        state_nxt = EXPIRED;
                    end else begin
                        count_nxt = count - WIDTH'(1);
                        if (ones == 4'd0) begin
                            ones_nxt = BCD_NINE;
                            tens_nxt = tens - 4'd1;
                        end else begin
                            ones_nxt = ones - 4'd1;
                        end
                        if (count == WIDTH'(1)) begin
                            state_nxt = EXPIRED;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    // Resume edge does not decrement; counting continues next edge.
                    if (start && !pause)
                        state_nxt = RUN;
                end
                EXPIRED: begin
                    state_nxt = EXPIRED;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign running = (state == RUN);
    assign expired = (state == EXPIRED);

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter that runs on the 1 Hz clock domain.
- Counts seconds from a loaded value down to zero, then halts and flags expiry.
- Binary and BCD (tens/ones) views of the remaining count are maintained in lockstep for direct seven-segment use.
- Complements the free-running up-counter: same clock, same reset, opposite direction, with start/pause/expire control.

Parameters:
- WIDTH, 7, width of binary count and load value.
- MAX_LOAD, 99, saturation limit for loaded values; must be at most 99 so the BCD view stays two digits.

Ports:
- clk_1Hz  input  1  counting clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  synchronous load strobe, sampled on posedge.
- load_val  input  WIDTH  value to load; saturated to MAX_LOAD.
- start  input  1  begin or resume counting.
- pause  input  1  freeze counting.
- count  output  WIDTH  remaining seconds, binary, registered.
- tens  output  4  BCD tens digit of count, registered.
- ones  output  4  BCD ones digit of count, registered.
- running  output  1  high while in RUN.
- done  output  1  single-cycle pulse on the edge count reaches 0.
- expired  output  1  level, high while in EXPIRED.

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, tens=0, ones=0, running=0, done=0, expired=0. Reset mid-count aborts immediately; no done pulse is emitted.
- Input priority per edge: load > pause > start.
- FSM states: IDLE, RUN, PAUSE, EXPIRED. running = (state==RUN); expired = (state==EXPIRED).
- load, any state:
  - Next state IDLE.
  - count = min(load_val, MAX_LOAD); tens/ones = BCD of that value.
  - done=0. A running countdown is abandoned.
- IDLE:
  - start with count!=0 -> RUN. count is not decremented on this edge.
  - start with count==0 -> stay IDLE; no done pulse.
  - pause is ignored.
- RUN, each edge without load/pause:
  - count decrements by 1.
  - BCD decrement: if ones==0 then ones=9 and tens=tens-1, else ones=ones-1.
  - When count==1 at the edge: count becomes 0, next state EXPIRED, done=1 for exactly that one cycle.
- RUN with pause -> PAUSE. count is held; no decrement on that edge.
- PAUSE:
  - start (without pause) -> RUN. No decrement on the resume edge; decrementing resumes on the following edge.
  - Otherwise hold.
- EXPIRED:
  - count, tens and ones held at 0. No wrap to 127 or 99 under any input.
  - start and pause are ignored.
  - Only load or rst leaves this state.
- done is registered. It is 0 on every cycle except the one following the 1->0 transition edge.
- Simultaneous start and pause: pause wins (RUN->PAUSE, PAUSE stays, IDLE stays).
- Invariant at every edge: count == 10*tens + ones. The bench checks this continuously.
- Latency: start at edge k -> first decrement visible after edge k+1. Load at edge k -> value visible after edge k.

Decomposition:
- Shared package countdown_pkg holds:
  - State enum (IDLE, RUN, PAUSE, EXPIRED) with 2-bit encoding.
  - Constants MAX_LOAD_DEFAULT=99 and BCD_NINE=4'd9.
- One sub-module, bin2bcd_99: combinational 7-bit binary to two-digit BCD for 0..99. Used only on the load path. The decrement path updates BCD digits incrementally, with no division.

Test Plan:
- rst high mid-RUN at count=42 -> all outputs 0 immediately, state IDLE. After release, start does nothing until a load.
- load_val=12, load, then start held one cycle -> count sequence 12,12,11,...,1,0. tens/ones go 1/2 -> 1/1 -> 1/0 -> 0/9 ... 0/0. done high exactly one cycle at 0; expired stays 1; running 1->0.
- load_val=120 -> count=99, tens=9, ones=9. Run 100 edges -> ends at 0 with a single done pulse, then holds 0 for 10 further edges with start asserted.
- load 5, start, pause after count=3 for 4 cycles (count stays 3), then start and pause asserted together (stays PAUSE). Then start alone -> count 3 on the resume edge, then 2,1,0.
- load asserted while in RUN at count=7 with load_val=20 -> count=20, state IDLE, running=0, no done. Load while EXPIRED -> IDLE, expired=0.
- load_val=0, then start -> stays IDLE, done never asserts, count=0.
